fft_bf_scheduler: RTL and testbench

//  Sequencer for the radix-2 butterfly datapath (butterfly2) in the in-place FFT core.

---
 rtl/fft_bf_scheduler_if.sv | 26 ++
 rtl/fft_bf_scheduler.sv | 151 +++++++++++++++
 tb/tb_fft_bf_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bf_scheduler_if.sv
// Butterfly/RAM bus between the FFT sequencer and its datapath.
// Carries RAM strobes, leg addresses, twiddle index and the butterfly handshake.
interface fft_bf_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int TW_W   = 3
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [TW_W-1:0]   tw_idx;
  logic              bf_start;
  logic              bf_done;

  modport master (
    output rd_en, wr_en, addr0, addr1,
    output tw_idx, bf_start,
    input  bf_done
  );

  modport slave (
    input  rd_en, wr_en, addr0, addr1,
    input  tw_idx, bf_start,
    output bf_done
  );
endinterface

// File: rtl/fft_bf_scheduler.sv
// In-place radix-2 DIT FFT butterfly sequencer: read, issue, wait, write back.
// Optional butterfly watchdog enabled by defining BF_WATCHDOG_EN.
module fft_bf_scheduler #(
  parameter int LOG2N       = 4,
  parameter int ADDR_W      = 4,
  parameter int TW_W        = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [1:0]      o_stage,
  output logic [TW_W-1:0] o_bf_idx,
  output logic            o_error,
  fft_bf_scheduler_if.master bf
);

  typedef enum logic [2:0] {
    IDLE, READ, ISSUE, WAIT, WRITE, DONE
  } state_t;

  localparam logic [1:0]      ST_LAST = 2'(LOG2N - 1);
  localparam logic [TW_W-1:0] BF_LAST = {TW_W{1'b1}};

  state_t            state, state_d;
  logic [1:0]        stage_q, stage_d;
  logic [TW_W-1:0]   bf_q, bf_d;
  logic [ADDR_W-1:0] a0_q, a1_q;
  logic [TW_W-1:0]   tw_q;

  function automatic logic [ADDR_W-1:0] leg0(
    input logic [1:0] s, input logic [TW_W-1:0] b);
    logic [ADDR_W-1:0] bw, mask, pos, grp;
    bw   = ADDR_W'(b);
    mask = (ADDR_W'(1) << s) - ADDR_W'(1);
    pos  = bw & mask;
    grp  = bw >> s;
    return ((grp << 1) << s) | pos;
  endfunction

  function automatic logic [TW_W-1:0] twid(
    input logic [1:0] s, input logic [TW_W-1:0] b);
    logic [TW_W-1:0] mask;
    mask = (TW_W'(1) << s) - TW_W'(1);
    return (b & mask) << (ST_LAST - s);
  endfunction

`ifdef BF_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            err_q;

  assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign o_error = err_q;

  // Counter reads k on the k-th WAIT cycle after the start pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE)
        wd_cnt <= WD_W'(1);
      else if (state == WAIT)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (state == IDLE && i_start)
        err_q <= 1'b0;
      else if (state == WAIT && !bf.bf_done && wd_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_d = state;
    stage_d = stage_q;
    bf_d    = bf_q;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_d = READ;
          stage_d = '0;
          bf_d    = '0;
        end
      end
      READ:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bf.bf_done)
          state_d = WRITE;
`ifdef BF_WATCHDOG_EN
        else if (wd_hit)
          state_d = DONE;
`endif
      end
      WRITE: begin
        if (bf_q != BF_LAST) begin
          bf_d    = bf_q + TW_W'(1);
          state_d = READ;
        end else if (stage_q != ST_LAST) begin
          bf_d    = '0;
          stage_d = stage_q + 2'd1;
          state_d = READ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses load on entry to READ and hold through WRITE and idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      tw_q    <= '0;
    end else begin
      state   <= state_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      if (state_d == READ) begin
        a0_q <= leg0(stage_d, bf_d);
        a1_q <= leg0(stage_d, bf_d)
              + (ADDR_W'(1) << stage_d);
        tw_q <= twid(stage_d, bf_d);
      end
    end
  end

  assign bf.rd_en    = (state == READ);
  assign bf.bf_start = (state == ISSUE);
  assign bf.wr_en    = (state == WRITE);
  assign bf.addr0    = a0_q;
  assign bf.addr1    = a1_q;
  assign bf.tw_idx   = tw_q;
  assign o_done      = (state == DONE);
  assign o_busy      = (state != IDLE) && (state != DONE);
  assign o_stage     = stage_q;
  assign o_bf_idx    = bf_q;

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Scoreboard bench for fft_bf_scheduler: expected write-backs and done
// latencies are queued by the stimulus and checked by a negedge monitor.
module tb_fft_bf_scheduler;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [1:0] stage;
  logic [2:0] bfi;

  fft_bf_scheduler_if #(.ADDR_W(4), .TW_W(3)) bus ();

  fft_bf_scheduler #(
    .LOG2N(4), .ADDR_W(4), .TW_W(3), .TIMEOUT_CYC(64)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .o_stage (stage),
    .o_bf_idx(bfi),
    .o_error (err),
    .bf      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a0; int a1; int tw; int s; int b;
  } wb_t;

  wb_t exp_q[$];
  int  done_q[$];
  wb_t spot[6];

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int t0 = 0;
  int n_start = 0;
  int n_wr = 0;
  int n_done = 0;
  int lat = 1;
  bit spur = 1'b0;
  int cnt = 0;
  int snap0, snap1, snapt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Butterfly model: done after lat cycles, optional spurious done.
  always @(negedge clk) begin
    logic d;
    d = 1'b0;
    if (bus.bf_start) begin
      cnt = lat;
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      d = (cnt == 0);
    end
    if (spur && (bus.rd_en || bus.bf_start)) d = 1'b1;
    bus.bf_done = d;
  end

  always @(negedge clk) begin
    wb_t e;
    if (bus.bf_start) begin
      n_start++;
      snap0 = int'(bus.addr0);
      snap1 = int'(bus.addr1);
      snapt = int'(bus.tw_idx);
    end
    if (bus.wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_stage", int'(stage), e.s);
        chk("wb_bf", int'(bfi), e.b);
        chk("wb_addr0", int'(bus.addr0), e.a0);
        chk("wb_addr1", int'(bus.addr1), e.a1);
        chk("wb_tw", int'(bus.tw_idx), e.tw);
        chk("addr_stable", int'(bus.addr0) * 256 +
            int'(bus.addr1) * 16 + int'(bus.tw_idx),
            snap0 * 256 + snap1 * 16 + snapt);
      end
      foreach (spot[i])
        if (int'(stage) == spot[i].s && int'(bfi) == spot[i].b) begin
          chk("spot_addr0", int'(bus.addr0), spot[i].a0);
          chk("spot_addr1", int'(bus.addr1), spot[i].a1);
          chk("spot_tw", int'(bus.tw_idx), spot[i].tw);
        end
    end
    if (done) begin
      n_done++;
      if (done_q.size() == 0)
        chk("unexpected_done", 1, 0);
      else
        chk("done_latency", cyc - t0, done_q.pop_front());
    end
  end

  task automatic push_pass();
    for (int s = 0; s < 4; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++)
        for (int p = 0; p < span; p++) begin
          wb_t e;
          e.a0 = g * 2 * span + p;
          e.a1 = e.a0 + span;
          e.tw = p * ((N / 2) / span);
          e.s  = s;
          e.b  = g * span + p;
          exp_q.push_back(e);
        end
    end
  endtask

  task automatic pulse_start(input bit mark);
    @(negedge clk);
    if (mark) t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++)
      @(negedge clk);
    @(negedge clk);
    chk("done_seen", n_done - n0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: no summary after time limit");
    $fatal(1);
  end

  initial begin
    int any;
    spot[0] = '{0, 1, 0, 0, 0};
    spot[1] = '{14, 15, 0, 0, 7};
    spot[2] = '{5, 7, 4, 1, 3};
    spot[3] = '{9, 13, 2, 2, 5};
    spot[4] = '{0, 8, 0, 3, 0};
    spot[5] = '{7, 15, 7, 3, 7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr0", int'(bus.addr0), 0);
    chk("rst_addr1", int'(bus.addr1), 0);
    chk("rst_tw", int'(bus.tw_idx), 0);
    chk("rst_stage", int'(stage) * 8 + int'(bfi), 0);
    chk("rst_error", int'(err), 0);
    any = 0;
    repeat (20) begin
      @(negedge clk);
      any |= int'(busy | bus.rd_en | bus.wr_en | bus.bf_start | done);
    end
    chk("idle_quiet", any, 0);

    // full pass, latency 1
    lat = 1; n_start = 0; n_wr = 0;
    push_pass();
    done_q.push_back(129);
    pulse_start(1'b1);
    chk("busy_after_start", int'(busy), 1);
    wait_done(400);
    chk("pass1_starts", n_start, 32);
    chk("pass1_writes", n_wr, 32);
    chk("pass1_left", exp_q.size(), 0);
    chk("hold_addr0", int'(bus.addr0), 7);
    chk("hold_addr1", int'(bus.addr1), 15);
    chk("hold_tw", int'(bus.tw_idx), 7);
    chk("idle_busy", int'(busy), 0);

    // latency 5
    lat = 5; n_start = 0; n_wr = 0;
    push_pass();
    done_q.push_back(257);
    pulse_start(1'b1);
    wait_done(600);
    chk("pass2_writes", n_wr, 32);
    chk("pass2_left", exp_q.size(), 0);

    // mid-pass start and spurious done in READ/ISSUE
    lat = 3; spur = 1'b1; n_start = 0; n_wr = 0;
    push_pass();
    done_q.push_back(193);
    pulse_start(1'b1);
    repeat (40) @(negedge clk);
    pulse_start(1'b0);
    wait_done(600);
    spur = 1'b0;
    chk("pass3_writes", n_wr, 32);
    chk("pass3_left", exp_q.size(), 0);

    // reset during WAIT of s=2,b=4
    lat = 10; n_wr = 0;
    push_pass();
    pulse_start(1'b1);
    any = 0;
    for (int i = 0; i < 2000 && any == 0; i++) begin
      @(negedge clk);
      if (bus.bf_start && stage == 2'd2 && bfi == 3'd4) any = 1;
    end
    chk("reached_s2b4", any, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobes", int'(bus.rd_en | bus.wr_en | bus.bf_start | done), 0);
    chk("abort_addr", int'(bus.addr0) + int'(bus.addr1) + int'(bus.tw_idx), 0);
    chk("abort_stage", int'(stage) * 8 + int'(bfi), 0);
    chk("abort_writes", n_wr, 20);
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("after_abort_busy", int'(busy), 0);

    // start together with reset: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start", int'(busy), 0);

`ifdef BF_WATCHDOG_EN
    lat = 0; n_wr = 0;
    done_q.push_back(66);
    pulse_start(1'b1);
    wait_done(200);
    chk("wd_error", int'(err), 1);
    chk("wd_writes", n_wr, 0);
    pulse_start(1'b0);
    chk("wd_error_clear", int'(err), 0);
    do_reset();
`else
    lat = 0; n_wr = 0;
    pulse_start(1'b1);
    repeat (200) @(negedge clk);
    chk("hang_busy", int'(busy), 1);
    chk("hang_error", int'(err), 0);
    chk("hang_writes", n_wr, 0);
    do_reset();
`endif
    repeat (5) @(negedge clk);
    chk("final_done_left", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
